sprite_fetch: RTL
=================

SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: ROM word address of sprite 0, row 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  draw request present.
REQ-005 req_ready  output  1  block idle and accepting a request.
REQ-006 req_sprite  input  6  sprite index, 0..63.
REQ-007 req_flip  input  1  1 = horizontal mirror.
REQ-008 rom_addr  output  16  word address to the ROM; registered.
REQ-009 rom_data  input  16  ROM read data, valid one cycle after rom_addr.
REQ-010 pix_valid  output  1  pixel output valid.
REQ-011 pix_ready  input  1  downstream accepts pixel.
REQ-012 pix_on  output  1  pixel value; 1 = opaque.
REQ-013 pix_col  output  4  pixel column 0..15, screen order.
REQ-014 pix_row  output  4  pixel row 0..15.
REQ-015 pix_last  output  1  marks row 15, col 15.
REQ-016 busy  output  1  request in progress.

Function
REQ-017 Sprite format: 16 rows x 16 px, 1 bpp, one 16-bit ROM word per row; row r of sprite s is at BASE_ADDR + s*16 + r, modulo 2^16.
REQ-018 States: IDLE, FETCH, CAPTURE, EMIT; req_ready = (state == IDLE); busy = !req_ready.
REQ-019 IDLE: on req_valid, latch req_sprite and req_flip, set rom_addr = BASE_ADDR + sprite*16, row counter = 0, go to FETCH. Inputs are ignored in every other state.
REQ-020 FETCH: hold rom_addr for one cycle, then go to CAPTURE. This cycle covers the ROM's 1-cycle registered read latency.
REQ-021 CAPTURE: load rom_data into a 16-bit shift register, set column counter = 0, go to EMIT.
REQ-022 EMIT: pix_valid = 1.
  - flip = 0: pix_on is the shift register's bit (15 - col).
  - flip = 1: pix_on is bit col.
  - pix_col = col; pix_row = row.
REQ-023 Handshake: a pixel transfers on a cycle with pix_valid && pix_ready.
  - While pix_ready = 0, pix_on, pix_col, pix_row and pix_last SHALL hold stable.
  - pix_valid SHALL NOT drop until the pixel transfers.
REQ-024 On a transfer with col < 15: col increments.
REQ-025 On a transfer with col = 15 and row < 15: row increments, rom_addr increments by 1, go to FETCH.
REQ-026 On a transfer with col = 15 and row = 15 (pix_last = 1): go to IDLE.
REQ-027 pix_last = 1 only when pix_valid, row = 15 and col = 15.
REQ-028 pix_valid = 0 in IDLE, FETCH and CAPTURE.
REQ-029 Timing with pix_ready held high:
  - first pixel valid 3 cycles after the req_valid accept edge;
  - each row takes 18 cycles;
  - a full sprite takes 288 cycles from accept to the return to IDLE.
REQ-030 A new request is accepted no earlier than the cycle after the return to IDLE, so req_ready and pix_last are never high in the same cycle.
REQ-031 Address wrap: with BASE_ADDR + s*16 + r > 16'hFFFF, rom_addr wraps modulo 2^16 and no error is flagged.
REQ-032 rom_data is sampled only in CAPTURE; its value in other states has no effect.

Reset
REQ-033 rst_n low, at any time including mid-sprite, SHALL immediately force:
  - state = IDLE, req_ready = 1, busy = 0;
  - pix_valid = 0, pix_on = 0, pix_col = 0, pix_row = 0, pix_last = 0;
  - rom_addr = 16'h0000;
  - internal counters, shift register and latched flip cleared.
REQ-034 After rst_n rises, the first request is accepted on the first rising edge at which req_valid = 1.

Verification
REQ-035 Basic fetch:
  - stimulus: BASE_ADDR = 0; sprite 2; ROM row words 16'h8001; pix_ready = 1.
  - response: rom_addr steps 0x20..0x2F; each row emits pix_on = 1 at cols 0 and 15, 0 elsewhere; pix_last at row 15 col 15; 288 cycles total.
REQ-036 Flip:
  - stimulus: sprite 0; row 0 word 16'hC000; req_flip = 1.
  - response: row 0 pix_on = 1 only at cols 14 and 15.
REQ-037 Backpressure:
  - stimulus: pix_ready toggled 1,0,0,1 during row 3.
  - response: outputs stable while stalled; no pixel lost or duplicated; 256 transfers total.
REQ-038 Wrap:
  - stimulus: BASE_ADDR = 16'hFFF8; sprite 0.
  - response: rom_addr goes FFF8..FFFF, then 0000..0007.
REQ-039 Reset mid-operation:
  - stimulus: rst_n asserted at row 7 col 5.
  - response: pix_valid = 0 and req_ready = 1 immediately.
  - follow-up: a new request for sprite 1 restarts at rom_addr 0x10, row 0.
REQ-040 Back-to-back requests:
  - stimulus: req_valid held high.
  - response: second accept occurs on the edge after the IDLE return; req_ready = 0 throughout the first sprite.

Source files
------------

// File: rtl/sprite_fetch_if.sv
// ---------------------------------------------------------------------------
// sprite_fetch_if
// Bundles the request handshake, the ROM read port and the pixel stream of
// the sprite fetcher.
//   req_valid / req_ready / req_sprite / req_flip : draw request handshake
//   rom_addr / rom_data                           : ROM word address and data
//   pix_valid / pix_ready / pix_on / pix_col /
//   pix_row / pix_last                            : pixel stream handshake
//   busy                                          : request in progress
// Modport slave is the fetcher; modport master is its environment.
// ---------------------------------------------------------------------------
interface sprite_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_sprite;
    logic        req_flip;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_on;
    logic [3:0]  pix_col;
    logic [3:0]  pix_row;
    logic        pix_last;
    logic        busy;

    modport slave (
        input  req_valid, req_sprite, req_flip, rom_data, pix_ready,
        output req_ready, rom_addr, pix_valid, pix_on, pix_col, pix_row,
               pix_last, busy
    );

    modport master (
        output req_valid, req_sprite, req_flip, rom_data, pix_ready,
        input  req_ready, rom_addr, pix_valid, pix_on, pix_col, pix_row,
               pix_last, busy
    );
endinterface

// File: rtl/sprite_fetch.sv
// ---------------------------------------------------------------------------
// sprite_fetch
// Fetches a 16x16, 1 bpp sprite from ROM (one 16-bit word per row, row r of
// sprite s at BASE_ADDR + s*16 + r, wrapping modulo 2^16) and streams its
// pixels in screen order over a valid/ready handshake, optionally mirrored
// horizontally.
// Ports:
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : sprite_fetch_if.slave (request, ROM port, pixel stream, busy)
// ---------------------------------------------------------------------------
module sprite_fetch #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    sprite_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t      state_r;
    logic        flip_r;
    logic [3:0]  row_r;
    logic [3:0]  col_r;
    logic [15:0] shreg_r;
    logic [15:0] rom_addr_r;
    logic        req_ready_r;
    logic        busy_r;
    logic        pix_valid_r;
    logic        pix_on_r;
    logic        pix_last_r;

    logic        xfer_s;
    logic [15:0] shifted_s;

    // The pixel to show next always sits at one end of the shift register:
    // bit 15 for normal order, bit 0 when mirrored.
    function automatic logic lead_bit(input logic [15:0] w, input logic flip);
        logic b;
        if (flip) begin
            b = w[0];
        end else begin
            b = w[15];
        end
        return b;
    endfunction

    // Transfer detect and the shift register advanced by one pixel.
    always_comb begin
        xfer_s    = 1'b0;
        shifted_s = 16'h0000;
        xfer_s    = pix_valid_r & bus.pix_ready;
        if (flip_r) begin
            shifted_s = {1'b0, shreg_r[15:1]};
        end else begin
            shifted_s = {shreg_r[14:0], 1'b0};
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            flip_r      <= 1'b0;
            row_r       <= 4'd0;
            col_r       <= 4'd0;
            shreg_r     <= 16'h0000;
            rom_addr_r  <= 16'h0000;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_on_r    <= 1'b0;
            pix_last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        flip_r      <= bus.req_flip;
                        // 16-bit add wraps naturally modulo 2^16
                        rom_addr_r  <= BASE_ADDR + {6'b000000, bus.req_sprite, 4'b0000};
                        row_r       <= 4'd0;
                        col_r       <= 4'd0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= FETCH;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                FETCH: begin
                    // Address was presented last edge; the ROM word arrives next.
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    shreg_r     <= bus.rom_data;
                    col_r       <= 4'd0;
                    // First pixel comes straight from the ROM word so it is
                    // valid in the same cycle the shift register is loaded.
                    pix_on_r    <= lead_bit(bus.rom_data, flip_r);
                    pix_valid_r <= 1'b1;
                    pix_last_r  <= 1'b0;
                    state_r     <= EMIT;
                end
                EMIT: begin
                    if (xfer_s) begin
                        if (col_r != 4'd15) begin
                            col_r      <= col_r + 4'd1;
                            shreg_r    <= shifted_s;
                            pix_on_r   <= lead_bit(shifted_s, flip_r);
                            pix_last_r <= (row_r == 4'd15) && (col_r == 4'd14);
                        end else begin
                            pix_valid_r <= 1'b0;
                            pix_last_r  <= 1'b0;
                            if (row_r != 4'd15) begin
                                row_r      <= row_r + 4'd1;
                                rom_addr_r <= rom_addr_r + 16'd1;
                                state_r    <= FETCH;
                            end else begin
                                req_ready_r <= 1'b1;
                                busy_r      <= 1'b0;
                                state_r     <= IDLE;
                            end
                        end
                    end else begin
                        // Stalled: every pixel output holds.
                        state_r <= EMIT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    pix_valid_r <= 1'b0;
                    pix_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.busy      = busy_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.pix_on    = pix_on_r;
    assign bus.pix_col   = col_r;
    assign bus.pix_row   = row_r;
    assign bus.pix_last  = pix_last_r;

endmodule
